cacheline_burst_adaptor: RTL
============================

Name: cacheline_burst_adaptor

Overview:
Downstream neighbour of the pipelined cache datapath, on its memory port. Converts one 256-bit cacheline read or writeback into a 4-beat, 64-bit burst on the physical memory bus. Returns the assembled line plus a one-cycle response to the cache controller.

Parameters:
BEAT_W, 64, memory data-bus width in bits; LINE_W/BEAT_W must equal 4.
LINE_W, 256, cacheline width in bits.
TIMEOUT_CYCLES, 1024, stall limit per beat; used only with CLA_TIMEOUT_EN.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
line_i  in  256  writeback data from the cache (cacheline_data_out)
line_o  out  256  assembled line to the cache (data_from_mem)
address_i  in  32  line address from the cache (address_to_mem)
read_i  in  1  cache line-fill request
write_i  in  1  cache writeback request
resp_o  out  1  one-cycle done pulse to the cache
burst_i  in  64  memory read beat
burst_o  out  64  memory write beat
address_o  out  32  latched burst address to memory
read_o  out  1  memory read request
write_o  out  1  memory write request
resp_i  in  1  memory beat-valid / beat-accepted strobe
error_o  out  1  timeout pulse; constant 0 without CLA_TIMEOUT_EN

Behaviour:
- Reset: state IDLE; beat counter 0; line_o, burst_o, address_o all 0; read_o, write_o, resp_o, error_o all 0. An asserted rst aborts any burst immediately. The next request starts cleanly.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE, write_i=1:
  - Latch address_i with bits [4:0] forced to 0.
  - Latch line_i into the write buffer; counter=0; go to WR_BURST.
  - write_i has priority if read_i is also 1.
- IDLE, read_i=1 (write_i=0): latch the aligned address, counter=0, go to RD_BURST.
- IDLE with neither request: hold state; line_o keeps its value.
- RD_BURST:
  - read_o=1 continuously.
  - Each cycle with resp_i=1: write burst_i into line_o[64*k +: 64], where k=counter, then counter++.
  - When resp_i=1 and counter=3: go to DONE.
  - resp_i=0 cycles are wait states; nothing changes.
- WR_BURST:
  - write_o=1 continuously.
  - burst_o = buffer[64*k +: 64], combinational from counter.
  - Each cycle with resp_i=1: counter++.
  - When resp_i=1 and counter=3: go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0.
  - Next state is always IDLE.
  - line_o is stable in DONE and stays stable until the next read burst writes beat 0.
- Cache contract: read_i and write_i are held until resp_o, then dropped combinationally. Requests asserted in any non-IDLE state are ignored. No request is queued.
- address_o stays constant for the whole burst and does not increment per beat. Beat order is fixed: 0, 1, 2, 3, lowest bits first.
- The counter is 2 bits and wraps to 0 on DONE entry.
- resp_i seen in IDLE or DONE is ignored.
- Latency: a read with zero wait states takes 4 cycles in RD_BURST plus 1 in DONE, so resp_o appears 5 cycles after read_i is sampled.

Optional Feature:
CLA_TIMEOUT_EN
- Defined:
  - A 16-bit stall counter runs in RD_BURST and WR_BURST. It clears on every resp_i=1 and on every state entry, and increments on each resp_i=0 cycle.
  - When it reaches TIMEOUT_CYCLES, the burst is abandoned: go to DONE, and error_o=1 in that same DONE cycle alongside resp_o.
  - line_o keeps the beats already received; the remaining beats keep their old contents.
- Not defined: no stall counter exists, error_o is tied to 0, and the block waits indefinitely for resp_i.

Test Plan:
- Read: address_i=0x0000_1234, 4 consecutive resp_i beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  -> address_o=0x0000_1220; read_o high 4 cycles; resp_o on cycle 5; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Writeback: line_i = {0xDDDD.., 0xCCCC.., 0xBBBB.., 0xAAAA..}, resp_i held 1.
  -> burst_o = 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. on consecutive cycles; write_o high 4 cycles; single resp_o pulse.
- Wait states: read with resp_i pattern 1,0,0,1,1,0,1.
  -> line_o fills in order; resp_o appears one cycle after the 7th cycle; read_o never drops mid-burst.
- Collision and back-to-back: read_i=write_i=1 in IDLE -> write burst executes. Immediately after resp_o, issue a read -> a second burst starts in the following IDLE cycle with no extra gap.
- Reset mid-burst: rst asserted after 2 read beats -> all outputs 0 asynchronously. A fresh read then completes normally, with beats stored from slot 0.
- With CLA_TIMEOUT_EN and TIMEOUT_CYCLES=8: read, 1 beat, then resp_i=0 for 8 cycles.
  -> resp_o=error_o=1 in the same cycle; state returns to IDLE; line_o[63:0] holds beat 0.

Source files
------------

// File: rtl/cacheline_burst_adaptor_if.sv
// Bus bundle for cacheline_burst_adaptor: cache-side line port plus memory-side beat port.
// The adaptor connects through the slave modport; the environment drives the master modport.
interface cacheline_burst_adaptor_if #(
   parameter int BEAT_W = 64,
   parameter int LINE_W = 256
);
   logic [LINE_W-1:0] line_i;
   logic [LINE_W-1:0] line_o;
   logic [31:0]       address_i;
   logic              read_i;
   logic              write_i;
   logic              resp_o;
   logic [BEAT_W-1:0] burst_i;
   logic [BEAT_W-1:0] burst_o;
   logic [31:0]       address_o;
   logic              read_o;
   logic              write_o;
   logic              resp_i;
   logic              error_o;

   modport slave (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o, error_o
   );

   modport master (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o, error_o
   );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Converts a cacheline read/writeback into a 4-beat burst on the memory bus.
// Optional per-beat stall timeout is enabled by defining CLA_TIMEOUT_EN.
module cacheline_burst_adaptor #(
   parameter int BEAT_W         = 64,
   parameter int LINE_W         = 256,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   cacheline_burst_adaptor_if.slave bus
);

   localparam logic [31:0] OFFSET_MASK = 32'(LINE_W / 8 - 1);

   if (LINE_W != 4 * BEAT_W || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
      $error("cacheline_burst_adaptor: unsupported parameter combination");
   end

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;

   state_e            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [LINE_W-1:0] wbuf_q, wbuf_d;
   logic [31:0]       addr_q, addr_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              resp_q, resp_d;
`ifdef CLA_TIMEOUT_EN
   logic [15:0]       stall_q, stall_d;
   logic              err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      wbuf_d  = wbuf_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            // Writeback wins when both requests arrive together.
            if (bus.write_i) begin
               addr_d  = bus.address_i & ~OFFSET_MASK;
               wbuf_d  = bus.line_i;
               cnt_d   = 2'd0;
               state_d = WR_BURST;
            end else if (bus.read_i) begin
               addr_d  = bus.address_i & ~OFFSET_MASK;
               cnt_d   = 2'd0;
               state_d = RD_BURST;
            end
         end
         RD_BURST: begin
            if (bus.resp_i) begin
               line_d[BEAT_W*cnt_q +: BEAT_W] = bus.burst_i;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = DONE;
            end
         end
         WR_BURST: begin
            if (bus.resp_i) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

`ifdef CLA_TIMEOUT_EN
      // Stall count restarts on every accepted beat and on every state change.
      stall_d = 16'd0;
      err_d   = 1'b0;
      if ((state_q == RD_BURST || state_q == WR_BURST) && !bus.resp_i) begin
         if (stall_q == 16'(TIMEOUT_CYCLES - 1)) begin
            state_d = DONE;
            cnt_d   = 2'd0;
            err_d   = 1'b1;
         end else begin
            stall_d = stall_q + 16'd1;
         end
      end
`endif

      rd_d   = (state_d == RD_BURST);
      wr_d   = (state_d == WR_BURST);
      resp_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         line_q  <= '0;
         wbuf_q  <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         resp_q  <= 1'b0;
`ifdef CLA_TIMEOUT_EN
         stall_q <= 16'd0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         wbuf_q  <= wbuf_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         resp_q  <= resp_d;
`ifdef CLA_TIMEOUT_EN
         stall_q <= stall_d;
         err_q   <= err_d;
`endif
      end
   end

   assign bus.line_o    = line_q;
   assign bus.address_o = addr_q;
   assign bus.read_o    = rd_q;
   assign bus.write_o   = wr_q;
   assign bus.resp_o    = resp_q;
   assign bus.burst_o   = (state_q == WR_BURST) ? wbuf_q[BEAT_W*cnt_q +: BEAT_W] : '0;
`ifdef CLA_TIMEOUT_EN
   assign bus.error_o   = err_q;
`else
   assign bus.error_o   = 1'b0;
`endif

endmodule
